// File: rtl/einstein_kbd_pkg.sv
// Shared types and scancode tables for the Einstein keyboard matrix interface.
// kbd_lookup maps a (extended, code) pair onto a matrix cell or a modifier id.
package einstein_kbd_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_PAUSE = 8'hE1;

  typedef enum logic [1:0] {
    KIND_NONE   = 2'd0,
    KIND_MATRIX = 2'd1,
    KIND_MOD    = 2'd2
  } key_kind_t;

  // For KIND_MOD entries the col field carries the modifier id.
  typedef struct packed {
    key_kind_t  kind;
    logic [2:0] row;
    logic [2:0] col;
  } key_map_t;

  localparam logic [2:0] MOD_SHIFT_L = 3'd0;
  localparam logic [2:0] MOD_SHIFT_R = 3'd1;
  localparam logic [2:0] MOD_CTRL    = 3'd2;
  localparam logic [2:0] MOD_GRAPH   = 3'd3;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_t;

  function automatic logic sc_ignored(input logic [7:0] code);
    return (code == 8'hAA) || (code == 8'hFA) || (code == 8'hFC) ||
           (code == 8'hEE) || (code == 8'h00) || (code == 8'hFF);
  endfunction

  function automatic key_map_t mx(input logic [2:0] r, input logic [2:0] c);
    return '{kind: KIND_MATRIX, row: r, col: c};
  endfunction

  function automatic key_map_t md(input logic [2:0] id);
    return '{kind: KIND_MOD, row: 3'd0, col: id};
  endfunction

  function automatic key_map_t kbd_lookup(input logic ext, input logic [7:0] code);
    key_map_t m;
    m = '{kind: KIND_NONE, row: 3'd0, col: 3'd0};
    if (!ext) begin
      case (code)
        8'h16: m = mx(3'd0, 3'd0);  8'h1E: m = mx(3'd0, 3'd1);
        8'h26: m = mx(3'd0, 3'd2);  8'h25: m = mx(3'd0, 3'd3);
        8'h2E: m = mx(3'd0, 3'd4);  8'h36: m = mx(3'd0, 3'd5);
        8'h3D: m = mx(3'd0, 3'd6);  8'h3E: m = mx(3'd0, 3'd7);
        8'h15: m = mx(3'd1, 3'd0);  8'h1D: m = mx(3'd1, 3'd1);
        8'h24: m = mx(3'd1, 3'd2);  8'h2D: m = mx(3'd1, 3'd3);
        8'h2C: m = mx(3'd1, 3'd4);  8'h35: m = mx(3'd1, 3'd5);
        8'h3C: m = mx(3'd1, 3'd6);  8'h43: m = mx(3'd1, 3'd7);
        8'h44: m = mx(3'd2, 3'd0);  8'h4D: m = mx(3'd2, 3'd1);
        8'h46: m = mx(3'd2, 3'd2);  8'h45: m = mx(3'd2, 3'd3);
        8'h4E: m = mx(3'd2, 3'd4);  8'h55: m = mx(3'd2, 3'd5);
        8'h1A: m = mx(3'd3, 3'd0);  8'h1C: m = mx(3'd3, 3'd1);
        8'h1B: m = mx(3'd3, 3'd2);  8'h23: m = mx(3'd3, 3'd3);
        8'h2B: m = mx(3'd3, 3'd4);  8'h34: m = mx(3'd3, 3'd5);
        8'h33: m = mx(3'd3, 3'd6);  8'h3B: m = mx(3'd3, 3'd7);
        8'h42: m = mx(3'd4, 3'd0);  8'h4B: m = mx(3'd4, 3'd1);
        8'h4C: m = mx(3'd4, 3'd2);  8'h52: m = mx(3'd4, 3'd3);
        8'h22: m = mx(3'd5, 3'd0);  8'h21: m = mx(3'd5, 3'd1);
        8'h2A: m = mx(3'd5, 3'd2);  8'h32: m = mx(3'd5, 3'd3);
        8'h31: m = mx(3'd5, 3'd4);  8'h3A: m = mx(3'd5, 3'd5);
        8'h29: m = mx(3'd6, 3'd0);  8'h5A: m = mx(3'd6, 3'd1);
        8'h66: m = mx(3'd6, 3'd2);  8'h76: m = mx(3'd6, 3'd3);
        8'h0D: m = mx(3'd6, 3'd4);
        8'h05: m = mx(3'd7, 3'd0);  8'h06: m = mx(3'd7, 3'd1);
        8'h04: m = mx(3'd7, 3'd2);  8'h0C: m = mx(3'd7, 3'd3);
        8'h12: m = md(MOD_SHIFT_L);
        8'h59: m = md(MOD_SHIFT_R);
        8'h14: m = md(MOD_CTRL);
        8'h11: m = md(MOD_GRAPH);
        default: ;
      endcase
    end else begin
      case (code)
        8'h75: m = mx(3'd7, 3'd4);  8'h72: m = mx(3'd7, 3'd5);
        8'h6B: m = mx(3'd7, 3'd6);  8'h74: m = mx(3'd7, 3'd7);
        8'h14: m = md(MOD_CTRL);
        8'h11: m = md(MOD_GRAPH);
        default: ;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/einstein_kbd_matrix_ps2_rx.sv
// PS/2 device-to-host receiver: synchroniser, clock deglitch, frame FSM
// and inter-edge timeout. Emits one byte_vld pulse per good frame.
module einstein_kbd_matrix_ps2_rx
  import einstein_kbd_pkg::*;
#(
  parameter int FILTER_CYC  = 8,
  parameter int TIMEOUT_CYC = 40000
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_vld,
  output logic [7:0] rx_byte,
  output logic       rx_err
);

  localparam int FW = $clog2(FILTER_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]    clk_sync_reg;
  logic [1:0]    data_sync_reg;
  logic          filt_reg;
  logic [FW-1:0] flt_cnt_reg;
  logic          fall_reg;
  logic          bit_reg;
  rx_state_t     state_reg, state_next;
  logic [2:0]    bit_cnt_reg;
  logic [7:0]    shift_reg;
  logic [TW-1:0] tmo_cnt_reg;
  logic          frame_ok, frame_bad, tmo_hit;

  // Filtered level flips only after FILTER_CYC consecutive differing samples.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      clk_sync_reg  <= 2'b11;
      data_sync_reg <= 2'b11;
      filt_reg      <= 1'b1;
      flt_cnt_reg   <= '0;
      fall_reg      <= 1'b0;
      bit_reg       <= 1'b1;
    end else begin
      clk_sync_reg  <= {clk_sync_reg[0], ps2_clk};
      data_sync_reg <= {data_sync_reg[0], ps2_data};
      fall_reg      <= 1'b0;
      if (clk_sync_reg[1] == filt_reg) begin
        flt_cnt_reg <= '0;
      end else if (flt_cnt_reg == FW'(FILTER_CYC - 1)) begin
        flt_cnt_reg <= '0;
        filt_reg    <= clk_sync_reg[1];
        fall_reg    <= filt_reg;
        bit_reg     <= data_sync_reg[1];
      end else begin
        flt_cnt_reg <= flt_cnt_reg + 1'b1;
      end
    end
  end

  assign tmo_hit = (state_reg != RX_IDLE) && (tmo_cnt_reg == TW'(TIMEOUT_CYC));

  always_comb begin
    state_next = state_reg;
    frame_ok   = 1'b0;
    frame_bad  = 1'b0;
    if (tmo_hit) begin
      state_next = RX_IDLE;
      frame_bad  = 1'b1;
    end else if (fall_reg) begin
      case (state_reg)
        RX_IDLE:   if (!bit_reg) state_next = RX_DATA;
        RX_DATA:   if (bit_cnt_reg == 3'd7) state_next = RX_PARITY;
        RX_PARITY: begin
          if (^{shift_reg, bit_reg}) begin
            state_next = RX_STOP;
          end else begin
            state_next = RX_IDLE;
            frame_bad  = 1'b1;
          end
        end
        RX_STOP: begin
          state_next = RX_IDLE;
          frame_ok   = bit_reg;
          frame_bad  = ~bit_reg;
        end
        default:   state_next = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_reg   <= RX_IDLE;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      tmo_cnt_reg <= '0;
      byte_vld    <= 1'b0;
      rx_err      <= 1'b0;
    end else begin
      state_reg <= state_next;
      byte_vld  <= frame_ok;
      rx_err    <= frame_bad;
      if (state_next == RX_IDLE || fall_reg) begin
        tmo_cnt_reg <= '0;
      end else begin
        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
      end
      if (state_reg == RX_IDLE) begin
        bit_cnt_reg <= '0;
      end else if (fall_reg && state_reg == RX_DATA) begin
        shift_reg   <= {bit_reg, shift_reg[7:1]};
        bit_cnt_reg <= bit_cnt_reg + 1'b1;
      end
    end
  end

  assign rx_byte = shift_reg;

endmodule

// File: rtl/einstein_kbd_matrix.sv
// Einstein keyboard matrix: decodes PS/2 scancodes into an 8x8 key-down
// matrix plus modifiers and answers the PSG row scan with column sense.
module einstein_kbd_matrix
  import einstein_kbd_pkg::*;
#(
  parameter int FILTER_CYC  = 8,
  parameter int TIMEOUT_CYC = 40000
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic [7:0] kb_row,
  output logic [7:0] kb_col,
  output logic       kb_shift,
  output logic       kb_ctrl,
  output logic       kb_graph,
  output logic       rx_err
);

  logic       byte_vld;
  logic [7:0] rx_byte;

  einstein_kbd_matrix_ps2_rx #(
    .FILTER_CYC (FILTER_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_rx (
    .clk_sys (clk_sys),
    .reset   (reset),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .byte_vld(byte_vld),
    .rx_byte (rx_byte),
    .rx_err  (rx_err)
  );

  logic [7:0] key_reg [8];
  logic [7:0] key_next [8];
  logic       ext_reg, ext_next;
  logic       brk_reg, brk_next;
  logic [2:0] skip_reg, skip_next;
  logic       lsh_reg, lsh_next;
  logic       rsh_reg, rsh_next;
  logic       ctrl_reg, ctrl_next;
  logic       graph_reg, graph_next;
  key_map_t   map;
  logic [7:0] col_next;

  assign map = kbd_lookup(ext_reg, rx_byte);

  // Held flags are active-high internally; outputs invert them.
  always_comb begin
    key_next   = key_reg;
    ext_next   = ext_reg;
    brk_next   = brk_reg;
    skip_next  = skip_reg;
    lsh_next   = lsh_reg;
    rsh_next   = rsh_reg;
    ctrl_next  = ctrl_reg;
    graph_next = graph_reg;
    if (byte_vld) begin
      if (skip_reg != 3'd0) begin
        skip_next = skip_reg - 3'd1;
      end else if (rx_byte == SC_EXT) begin
        ext_next = 1'b1;
      end else if (rx_byte == SC_BRK) begin
        brk_next = 1'b1;
      end else if (rx_byte == SC_PAUSE) begin
        skip_next = 3'd7;
      end else if (!sc_ignored(rx_byte)) begin
        case (map.kind)
          KIND_MATRIX: key_next[map.row][map.col] = ~brk_reg;
          KIND_MOD: begin
            case (map.col)
              MOD_SHIFT_L: lsh_next   = ~brk_reg;
              MOD_SHIFT_R: rsh_next   = ~brk_reg;
              MOD_CTRL:    ctrl_next  = ~brk_reg;
              MOD_GRAPH:   graph_next = ~brk_reg;
              default: ;
            endcase
          end
          default: ;
        endcase
        ext_next = 1'b0;
        brk_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      key_reg   <= '{default: '0};
      ext_reg   <= 1'b0;
      brk_reg   <= 1'b0;
      skip_reg  <= '0;
      lsh_reg   <= 1'b0;
      rsh_reg   <= 1'b0;
      ctrl_reg  <= 1'b0;
      graph_reg <= 1'b0;
    end else begin
      key_reg   <= key_next;
      ext_reg   <= ext_next;
      brk_reg   <= brk_next;
      skip_reg  <= skip_next;
      lsh_reg   <= lsh_next;
      rsh_reg   <= rsh_next;
      ctrl_reg  <= ctrl_next;
      graph_reg <= graph_next;
    end
  end

  genvar gi, gj;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_col
      logic [7:0] hit;
      for (gj = 0; gj < 8; gj++) begin : g_row
        assign hit[gj] = key_reg[gj][gi] & ~kb_row[gj];
      end
      assign col_next[gi] = ~|hit;
    end
  endgenerate

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      kb_col   <= 8'hFF;
      kb_shift <= 1'b1;
      kb_ctrl  <= 1'b1;
      kb_graph <= 1'b1;
    end else begin
      kb_col   <= col_next;
      kb_shift <= ~(lsh_reg | rsh_reg);
      kb_ctrl  <= ~ctrl_reg;
      kb_graph <= ~graph_reg;
    end
  end

endmodule

// File: tb/tb_einstein_kbd_matrix.sv
// Directed bench for einstein_kbd_matrix: drives PS/2 frames bit by bit and
// checks the row scan, modifiers and error pulses against hand-computed values.
module tb_einstein_kbd_matrix;

  localparam int FILT = 8;
  localparam int TMO  = 2000;
  localparam int HALF = 20;

  logic       clk_sys = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] kb_row = 8'h00;
  logic [7:0] kb_col;
  logic       kb_shift, kb_ctrl, kb_graph, rx_err;

  int n_cmp = 0;
  int n_bad = 0;
  int err_seen = 0;
  int err_base;

  einstein_kbd_matrix #(.FILTER_CYC(FILT), .TIMEOUT_CYC(TMO)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .kb_row  (kb_row),
    .kb_col  (kb_col),
    .kb_shift(kb_shift),
    .kb_ctrl (kb_ctrl),
    .kb_graph(kb_graph),
    .rx_err  (rx_err)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) if (rx_err) err_seen <= err_seen + 1;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end else begin
      $display("ok   %s: %02h", tag, got);
    end
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    repeat (HALF) @(posedge clk_sys);
    ps2_clk = 1'b0;
    repeat (HALF) @(posedge clk_sys);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input logic bad_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(code[i]);
    send_bit(~^code ^ bad_par);
    send_bit(1'b1);
    ps2_data = 1'b1;
    repeat (60) @(posedge clk_sys);
  endtask

  task automatic send_seq(input logic [7:0] codes[$]);
    foreach (codes[i]) send_frame(codes[i], 1'b0);
  endtask

  task automatic set_row(input logic [7:0] r);
    @(negedge clk_sys);
    kb_row = r;
    @(negedge clk_sys);
    @(negedge clk_sys);
  endtask

  initial begin
    repeat (5) @(negedge clk_sys);
    chk("reset_col", kb_col, 8'hFF);
    chk("reset_mods", {5'b0, kb_shift, kb_ctrl, kb_graph}, 8'h07);
    chk("reset_err", {7'b0, rx_err}, 8'h00);
    reset = 1'b0;
    repeat (5) @(posedge clk_sys);

    // 1: A press and release on row 3
    set_row(8'hF7);
    send_frame(8'h1C, 1'b0);
    set_row(8'hF7);
    chk("t1_press", kb_col, 8'hFD);
    send_seq('{8'hF0, 8'h1C});
    set_row(8'hF7);
    chk("t1_release", kb_col, 8'hFF);

    // 2: row sweep with A held
    send_frame(8'h1C, 1'b0);
    for (int r = 0; r < 8; r++) begin
      logic [7:0] sel;
      sel = ~(8'h01 << r);
      set_row(sel);
      chk($sformatf("t2_row%0d", r), kb_col, (r == 3) ? 8'hFD : 8'hFF);
    end
    set_row(8'h00);
    chk("t2_allrows", kb_col, 8'hFD);
    send_seq('{8'h15, 8'h1B});
    set_row(8'h00);
    chk("t2_three_keys", kb_col, 8'hF8);
    send_seq('{8'hF0, 8'h15, 8'hF0, 8'h1B, 8'hF0, 8'h1C});
    set_row(8'h00);
    chk("t2_cleared", kb_col, 8'hFF);

    // 3: modifiers
    send_frame(8'h12, 1'b0);
    @(negedge clk_sys); chk("t3_lshift", {7'b0, kb_shift}, 8'h00);
    send_frame(8'h59, 1'b0);
    send_seq('{8'hF0, 8'h12});
    @(negedge clk_sys); chk("t3_rshift_held", {7'b0, kb_shift}, 8'h00);
    send_seq('{8'hF0, 8'h59});
    @(negedge clk_sys); chk("t3_shift_up", {7'b0, kb_shift}, 8'h01);
    send_seq('{8'hE0, 8'h14});
    @(negedge clk_sys); chk("t3_rctrl", {7'b0, kb_ctrl}, 8'h00);
    send_seq('{8'hE0, 8'hF0, 8'h14, 8'h11});
    @(negedge clk_sys); chk("t3_ctrl_graph", {6'b0, kb_ctrl, kb_graph}, 8'h02);
    send_seq('{8'hF0, 8'h11});
    @(negedge clk_sys); chk("t3_graph_up", {7'b0, kb_graph}, 8'h01);

    // 4: parity error, timeout, then recovery
    set_row(8'hF7);
    err_base = err_seen;
    send_frame(8'h1C, 1'b1);
    chk("t4_par_err", 8'(err_seen - err_base), 8'd1);
    chk("t4_par_col", kb_col, 8'hFF);
    err_base = err_seen;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    repeat (TMO + 200) @(posedge clk_sys);
    chk("t4_tmo_err", 8'(err_seen - err_base), 8'd1);
    chk("t4_tmo_col", kb_col, 8'hFF);
    send_frame(8'h1C, 1'b0);
    set_row(8'hF7);
    chk("t4_recover", kb_col, 8'hFD);
    send_seq('{8'hF0, 8'h1C});

    // 5: Pause sequence swallowed, unmapped release ignored
    send_seq('{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h1C});
    set_row(8'h00);
    chk("t5_only_a", kb_col, 8'hFD);
    chk("t5_no_ctrl", {7'b0, kb_ctrl}, 8'h01);
    send_seq('{8'hE0, 8'hF0, 8'h7C});
    set_row(8'h00);
    chk("t5_prtscr", kb_col, 8'hFD);
    send_seq('{8'h1C});
    set_row(8'h00);
    chk("t5_typematic", kb_col, 8'hFD);

    // 6: async reset mid-frame
    send_frame(8'h12, 1'b0);
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_col", kb_col, 8'hFF);
    chk("t6_rst_mods", {5'b0, kb_shift, kb_ctrl, kb_graph}, 8'h07);
    @(negedge clk_sys);
    reset = 1'b0;
    repeat (100) @(posedge clk_sys);
    send_frame(8'h1C, 1'b0);
    set_row(8'h00);
    chk("t6_after", kb_col, 8'hFD);
    chk("t6_shift", {7'b0, kb_shift}, 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
